// File: rtl/dec_pkg.sv
// Shared types for the one-hot decoder / scan sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package dec_pkg;

    // Operating modes, encoded as seen on the 2-bit mode port.
    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DN     = 2'b10,
        MODE_SWEEP  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_SEL_W = 4;
    localparam int DEF_OUT_W = 1 << DEF_SEL_W;

    // One-hot of an index at the default width.
    function automatic logic [DEF_OUT_W-1:0] onehot(input logic [DEF_SEL_W-1:0] i);
        logic [DEF_OUT_W-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational enable + index to 2^SEL_W one-hot decoder.
// Latency: 0 cycles (pure combinational; the caller registers the result).
// Backpressure: none; output follows inputs.
//   en   in  1          when low the output is all-zero
//   idx  in  SEL_W      bit position to set
//   oh   out 2^SEL_W    one-hot (or all-zero) vector
module dec_onehot #(
    parameter int SEL_W = 4
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      idx,
    output logic [(2**SEL_W)-1:0] oh
);

    always_comb begin
        oh = '0;
        if (en) begin
            oh[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_scan_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with up/down/sweep scan sequencer.
// Latency: 1 cycle from sel/start to o/idx; every output is a flop.
// Backpressure: none; en=0 blanks o and freezes the sequencer in place.
//   clk, rst_n          clock, async active-low reset
//   en, mode, sel       enable, mode (DIRECT/UP/DN/SWEEP), index or scan start index
//   dwell, start, stop  per-index hold minus one, scan begin, scan abort
//   o, idx              registered one-hot output and its index
//   busy, wrap, done    scan active, wrap-around pulse, sweep complete pulse
module dec_scan_seq
    import dec_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  start,
    input  logic                  stop,
    output logic [(2**SEL_W)-1:0] o,
    output logic [SEL_W-1:0]      idx,
    output logic                  busy,
    output logic                  wrap,
    output logic                  done
);

    localparam int               OUT_W   = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

    state_t               state, state_n;
    mode_t                mode_q, mode_n, mode_in;
    logic [DWELL_W-1:0]   cnt, cnt_n;
    logic [SEL_W-1:0]     idx_n;
    logic                 o_en_n, busy_n, wrap_n, done_n;
    logic [OUT_W-1:0]     o_n;

    assign mode_in = mode_t'(mode);

    // Next-state decisions. The decoder is driven from the next index so the
    // output register captures onehot(idx_n) on the same edge as idx.
    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        cnt_n   = cnt;
        idx_n   = idx;
        o_en_n  = 1'b0;
        busy_n  = busy;
        wrap_n  = 1'b0;
        done_n  = 1'b0;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    if (mode_in == MODE_DIRECT) begin
                        idx_n  = sel;
                        o_en_n = 1'b1;
                        busy_n = 1'b0;
                    end else if (start && !stop) begin
                        mode_n  = mode_in;
                        idx_n   = sel;
                        cnt_n   = dwell;
                        o_en_n  = 1'b1;
                        busy_n  = 1'b1;
                        state_n = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end else if (start) begin
                        idx_n  = sel;
                        cnt_n  = dwell;
                        o_en_n = 1'b1;
                        if (mode_in == MODE_DIRECT) begin
                            // Restarting into DIRECT leaves the scan and decodes sel.
                            busy_n  = 1'b0;
                            state_n = ST_IDLE;
                        end else begin
                            mode_n = mode_in;
                        end
                    end else if (cnt != '0) begin
                        cnt_n  = cnt - DWELL_W'(1);
                        o_en_n = 1'b1;
                    end else begin
                        cnt_n  = dwell;
                        o_en_n = 1'b1;
                        case (mode_q)
                            MODE_UP: begin
                                idx_n  = idx + SEL_W'(1);
                                wrap_n = (idx == IDX_MAX);
                            end
                            MODE_DN: begin
                                idx_n  = idx - SEL_W'(1);
                                wrap_n = (idx == '0);
                            end
                            MODE_SWEEP: begin
                                if (idx == IDX_MAX) begin
                                    // Last index served: end of the single pass, idx stays at the top.
                                    o_en_n  = 1'b0;
                                    busy_n  = 1'b0;
                                    done_n  = 1'b1;
                                    state_n = ST_IDLE;
                                end else begin
                                    idx_n = idx + SEL_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    dec_onehot #(.SEL_W(SEL_W)) u_dec (
        .en  (o_en_n),
        .idx (idx_n),
        .oh  (o_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_DIRECT;
            cnt    <= '0;
            idx    <= '0;
            o      <= '0;
            busy   <= 1'b0;
            wrap   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            o      <= o_n;
            busy   <= busy_n;
            wrap   <= wrap_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Self-checking bench for dec_scan_seq: directed scenarios plus randomized scans.
// Latency: expects outputs one clock after the driving edge.
// Backpressure: drives en low at random to freeze the sequencer.
module tb_dec_scan_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  sel;
    logic [7:0]  dwell;
    logic        start;
    logic        stop;
    logic [15:0] o;
    logic [3:0]  idx;
    logic        busy;
    logic        wrap;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    logic en_prev = 1'b0;

    dec_scan_seq #(.SEL_W(4), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .dwell (dwell),
        .start (start),
        .stop  (stop),
        .o     (o),
        .idx   (idx),
        .busy  (busy),
        .wrap  (wrap),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_prev <= en;

    // Per-cycle invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks++;
            if (!$onehot0(o)) begin
                n_fail++;
                $display("FAIL onehot0: o=%h", o);
            end
            if (busy && en_prev) begin
                n_checks++;
                if (!$onehot(o)) begin
                    n_fail++;
                    $display("FAIL busy_onehot: o=%h busy=%b", o, busy);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_stop();
        en = 1'b1; start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || o !== 16'h0) begin
            n_fail++;
            $display("FAIL stop_idle: busy=%b o=%h want busy=0 o=0", busy, o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; sel = 4'd0; dwell = 8'd0;
        start = 1'b0; stop = 1'b0;
        #12;
        n_checks++;
        if ({o, idx, busy, wrap, done} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: o=%h idx=%0d busy=%b wrap=%b done=%b want all 0",
                     o, idx, busy, wrap, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (o !== 16'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: o=%h busy=%b want 0 0", o, busy);
        end
    endtask

    task automatic test_direct();
        logic [3:0] eidx;
        logic [15:0] one;
        one = 16'h1;
        mode = 2'b00; en = 1'b1; sel = 4'd5;
        tick();
        n_checks++;
        if (o !== 16'h0020 || idx !== 4'd5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_sel5: o=%h idx=%0d busy=%b want 0020 5 0", o, idx, busy);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if (o !== 16'h0 || idx !== 4'd5) begin
            n_fail++;
            $display("FAIL direct_en0: o=%h idx=%0d want 0000 5", o, idx);
        end
        eidx = 4'd5;
        for (int k = 0; k < 40; k++) begin
            en    = ($urandom_range(99) < 75);
            sel   = 4'($urandom);
            start = 1'($urandom);
            stop  = 1'($urandom);
            tick();
            if (en) eidx = sel;
            n_checks++;
            if (o !== (en ? (one << eidx) : 16'h0) || idx !== eidx || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL direct_rand: o=%h idx=%0d busy=%b want idx=%0d en=%b",
                         o, idx, busy, eidx, en);
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_scan_up();
        logic [15:0] exp_o [9] = '{16'h4000, 16'h4000, 16'h4000, 16'h8000, 16'h8000,
                                   16'h8000, 16'h0001, 16'h0001, 16'h0001};
        logic        exp_w [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        mode = 2'b01; sel = 4'd14; dwell = 8'd2; en = 1'b1; start = 1'b1;
        for (int t = 0; t < 9; t++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if (o !== exp_o[t] || wrap !== exp_w[t] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL scan_up t=%0d: o=%h wrap=%b busy=%b want o=%h wrap=%b busy=1",
                         t, o, wrap, busy, exp_o[t], exp_w[t]);
            end
        end
        do_stop();
    endtask

    task automatic test_scan_dn();
        logic [3:0] exp_i [4] = '{4'd1, 4'd0, 4'd15, 4'd14};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        mode = 2'b10; sel = 4'd1; dwell = 8'd0; en = 1'b1; start = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if (idx !== exp_i[t] || wrap !== exp_w[t]) begin
                n_fail++;
                $display("FAIL scan_dn t=%0d: idx=%0d wrap=%b want idx=%0d wrap=%b",
                         t, idx, wrap, exp_i[t], exp_w[t]);
            end
        end
        do_stop();
    endtask

    task automatic test_sweep();
        logic [15:0] exp_o [8] = '{16'h2000, 16'h2000, 16'h4000, 16'h4000,
                                   16'h8000, 16'h8000, 16'h0000, 16'h0000};
        logic [3:0]  exp_i [8] = '{4'd13, 4'd13, 4'd14, 4'd14, 4'd15, 4'd15, 4'd15, 4'd15};
        logic        exp_b [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        exp_d [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        mode = 2'b11; sel = 4'd13; dwell = 8'd1; en = 1'b1; start = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if (o !== exp_o[t] || idx !== exp_i[t] || busy !== exp_b[t] || done !== exp_d[t]) begin
                n_fail++;
                $display("FAIL sweep t=%0d: o=%h idx=%0d busy=%b done=%b want %h %0d %b %b",
                         t, o, idx, busy, done, exp_o[t], exp_i[t], exp_b[t], exp_d[t]);
            end
        end
    endtask

    task automatic test_start_stop();
        mode = 2'b01; sel = 4'd7; dwell = 8'd3; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_checks++;
        if (o !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop: o=%h busy=%b done=%b wrap=%b want all 0", o, busy, done, wrap);
        end
        tick();
        n_checks++;
        if (o !== 16'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_hold: o=%h busy=%b want 0 0", o, busy);
        end
        // Restart while running: new sel/mode/dwell take effect at once.
        mode = 2'b01; sel = 4'd2; dwell = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mode = 2'b10; sel = 4'd9; dwell = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (idx !== 4'd9 || o !== 16'h0200 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: idx=%0d o=%h busy=%b want 9 0200 1", idx, o, busy);
        end
        mode = 2'b01;
        tick();
        n_checks++;
        if (idx !== 4'd8 || o !== 16'h0100) begin
            n_fail++;
            $display("FAIL restart_step: idx=%0d o=%h want 8 0100", idx, o);
        end
        do_stop();
    endtask

    task automatic test_en_gap();
        mode = 2'b01; sel = 4'd3; dwell = 8'd5; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (o !== 16'h0 || idx !== 4'd3 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL en_gap k=%0d: o=%h idx=%0d busy=%b want 0000 3 1", k, o, idx, busy);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (o !== 16'h0008 || idx !== 4'd3) begin
                n_fail++;
                $display("FAIL en_resume k=%0d: o=%h idx=%0d want 0008 3", k, o, idx);
            end
        end
        tick();
        n_checks++;
        if (o !== 16'h0010 || idx !== 4'd4) begin
            n_fail++;
            $display("FAIL en_resume_step: o=%h idx=%0d want 0010 4", o, idx);
        end
        do_stop();
    endtask

    task automatic test_reset_mid();
        mode = 2'b01; sel = 4'd10; dwell = 8'd1; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o !== 16'h0 || idx !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: o=%h idx=%0d busy=%b want 0 0 0", o, idx, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (o !== 16'h0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_idle k=%0d: o=%h busy=%b want 0 0", k, o, busy);
            end
        end
        sel = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (o !== 16'h0040 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_restart: o=%h busy=%b want 0040 1", o, busy);
        end
        do_stop();
    endtask

    // Reference: after the start edge, t counts enabled edges; the index
    // advances one position every dwell+1 enabled edges.
    task automatic run_scan(input logic [1:0] m, input int s, input int d,
                            input int ncyc, input int en_pct);
        int          t, pos;
        bit          fin, stepped;
        logic [15:0] one, eo;
        logic [3:0]  eidx;
        logic        ebusy, ewrap, edone;
        one = 16'h1;
        mode = m; sel = 4'(s); dwell = 8'(d); en = 1'b1; start = 1'b1; stop = 1'b0;
        tick();
        start = 1'b0;
        t = 0; fin = 1'b0; eidx = 4'(s);
        n_checks++;
        if ({o, idx, busy, wrap, done} !== {one << eidx, eidx, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rand_start m=%0d s=%0d: o=%h idx=%0d busy=%b", m, s, o, idx, busy);
        end
        for (int k = 0; k < ncyc; k++) begin
            en    = ($urandom_range(99) < en_pct);
            sel   = 4'($urandom);
            mode  = 2'($urandom_range(3, 1));
            dwell = 8'(d);
            tick();
            ewrap = 1'b0; edone = 1'b0;
            if (!en || fin) begin
                eo = 16'h0;
                ebusy = !fin;
            end else begin
                t++;
                pos = t / (d + 1);
                stepped = (t % (d + 1)) == 0;
                ebusy = 1'b1;
                case (m)
                    2'b01: begin
                        eidx  = 4'((s + pos) & 15);
                        ewrap = stepped && eidx == 4'd0;
                    end
                    2'b10: begin
                        eidx  = 4'((s - pos) & 15);
                        ewrap = stepped && eidx == 4'd15;
                    end
                    default: begin
                        if (s + pos > 15) begin
                            fin   = 1'b1;
                            eidx  = 4'd15;
                            ebusy = 1'b0;
                            edone = 1'b1;
                        end else begin
                            eidx = 4'(s + pos);
                        end
                    end
                endcase
                eo = ebusy ? (one << eidx) : 16'h0;
            end
            n_checks++;
            if ({o, idx, busy, wrap, done} !== {eo, eidx, ebusy, ewrap, edone}) begin
                n_fail++;
                $display("FAIL rand_scan m=%0d s=%0d d=%0d t=%0d: o=%h idx=%0d b=%b w=%b dn=%b want %h %0d %b %b %b",
                         m, s, d, t, o, idx, busy, wrap, done, eo, eidx, ebusy, ewrap, edone);
            end
        end
        do_stop();
        n_checks++;
        if (idx !== eidx) begin
            n_fail++;
            $display("FAIL rand_stop_idx: idx=%0d want %0d", idx, eidx);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            run_scan(2'($urandom_range(3, 1)), int'($urandom_range(15)),
                     int'($urandom_range(3)), int'($urandom_range(60, 20)), 80);
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_up();
        test_scan_dn();
        test_sweep();
        test_start_stop();
        test_en_gap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
